// File: rtl/ucore_uart.sv
// ucore_uart: byte-wide register-bus UART responder (RX, TX, STATUS, CTRL)
// with 8N1 serialiser/deserialiser and a one-cycle receive interrupt pulse.
//
// Bus handshake (read and write channels are fully independent):
//   A request is accepted on the first rising edge where cen != 0 and the
//   channel's served flag is clear. Acceptance sets served and registers
//   a one-cycle ack on the following cycle (rdata is valid alongside rack).
//   served clears only when cen returns to 0, so a held cen is acknowledged
//   exactly once. With several cen bits set the lowest index is used.
module ucore_uart #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       aresetn,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic       uart_interrupt,
  input  logic [3:0] uart_rcen,
  output logic       uart_rack,
  output logic [7:0] uart_rdata,
  input  logic [3:0] uart_wcen,
  output logic       uart_wack,
  input  logic [7:0] uart_wdata
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  localparam logic [1:0] REG_RX     = 2'd0;
  localparam logic [1:0] REG_TX     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_WAIT  = 3'd4
  } rx_state_t;

  // ---------------------------------------------------------------------
  // Register state
  // ---------------------------------------------------------------------
  logic [7:0] rx_data;
  logic [7:0] tx_hold;
  logic [7:0] ctrl;
  logic       rx_valid;
  logic       rx_overrun;
  logic       frame_err;
  logic       tx_drop;
  logic       tx_go;
  logic       irq_q;

  logic       rd_served;
  logic       wr_served;
  logic       rack_q;
  logic       wack_q;
  logic [7:0] rdata_q;

  // TX engine
  tx_state_t  tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [2:0] tx_bit, tx_bit_n;
  logic       txd_q, txd_n;

  // RX engine
  rx_state_t  rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n;
  logic [2:0] rx_bit, rx_bit_n;
  logic [7:0] rx_shift, rx_shift_n;
  logic       rx_done;
  logic       ferr_set;
  logic       rxd_s1, rxd_s2, rxd_s3;
  logic       rx_fall;

  // ---------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------
  logic       rd_accept, wr_accept;
  logic [1:0] rd_sel, wr_sel;
  logic       rd_rx;
  logic       wr_tx, wr_status, wr_ctrl;
  logic       tx_load, tx_drop_set;
  logic       rx_store, overrun_set;
  logic [7:0] w1c;
  logic       tx_busy;
  logic [7:0] status_val;
  logic [7:0] rd_mux;

  assign rd_accept = (uart_rcen != 4'b0000) && !rd_served;
  assign wr_accept = (uart_wcen != 4'b0000) && !wr_served;

  // Lowest set enable bit selects the register for each channel
  always_comb begin
    rd_sel = REG_CTRL;
    if (uart_rcen[0])      rd_sel = REG_RX;
    else if (uart_rcen[1]) rd_sel = REG_TX;
    else if (uart_rcen[2]) rd_sel = REG_STATUS;
    wr_sel = REG_CTRL;
    if (uart_wcen[0])      wr_sel = REG_RX;
    else if (uart_wcen[1]) wr_sel = REG_TX;
    else if (uart_wcen[2]) wr_sel = REG_STATUS;
  end

  assign rd_rx     = rd_accept && (rd_sel == REG_RX);
  assign wr_tx     = wr_accept && (wr_sel == REG_TX);
  assign wr_status = wr_accept && (wr_sel == REG_STATUS);
  assign wr_ctrl   = wr_accept && (wr_sel == REG_CTRL);

  assign tx_busy     = (tx_state != TX_IDLE);
  // tx_go covers the single cycle between load and the START transition
  assign tx_load     = wr_tx && !tx_busy && !tx_go && ctrl[1];
  assign tx_drop_set = wr_tx && !tx_load;

  // A byte landing while unread data exists, or while RX is being read, overruns
  assign rx_store    = rx_done && !rx_valid && !rd_rx;
  assign overrun_set = rx_done && (rx_valid || rd_rx);

  assign w1c        = wr_status ? uart_wdata : 8'h00;
  assign status_val = {3'b000, tx_drop, frame_err, rx_overrun, tx_busy, rx_valid};

  // Read data multiplexer, sampled from pre-write register values
  always_comb begin
    rd_mux = 8'h00;
    case (rd_sel)
      REG_RX:     rd_mux = rx_data;
      REG_TX:     rd_mux = tx_hold;
      REG_STATUS: rd_mux = status_val;
      default:    rd_mux = ctrl;
    endcase
  end

  // Bus handshake: served flags, one-cycle acks and read data capture
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rd_served <= 1'b0;
      wr_served <= 1'b0;
      rack_q    <= 1'b0;
      wack_q    <= 1'b0;
      rdata_q   <= 8'h00;
    end else begin
      rd_served <= rd_accept || (rd_served && (uart_rcen != 4'b0000));
      wr_served <= wr_accept || (wr_served && (uart_wcen != 4'b0000));
      rack_q    <= rd_accept;
      wack_q    <= wr_accept;
      if (rd_accept) rdata_q <= rd_mux;
    end
  end

  // Register file, status flags (set beats W1C) and interrupt pulse
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_data    <= 8'h00;
      tx_hold    <= 8'h00;
      ctrl       <= 8'h03;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
      tx_drop    <= 1'b0;
      tx_go      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= uart_wdata;
      if (tx_load) tx_hold <= uart_wdata;
      tx_go <= tx_load;
      if (rx_store) rx_data <= rx_shift;
      if (rx_store)   rx_valid <= 1'b1;
      else if (rd_rx) rx_valid <= 1'b0;
      rx_overrun <= overrun_set || (rx_overrun && !w1c[2]);
      frame_err  <= ferr_set    || (frame_err  && !w1c[3]);
      tx_drop    <= tx_drop_set || (tx_drop    && !w1c[4]);
      irq_q      <= rx_store && ctrl[0];
    end
  end

  // ---------------------------------------------------------------------
  // TX engine
  // ---------------------------------------------------------------------
  // TX state register; txd is registered so it is glitch-free and idles high
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= 16'd0;
      tx_bit   <= 3'd0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      txd_q    <= txd_n;
    end
  end

  // TX next state: start bit, eight data bits LSB first, stop bit
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    txd_n      = txd_q;
    case (tx_state)
      TX_IDLE: begin
        txd_n = 1'b1;
        if (tx_go) begin
          tx_state_n = TX_START;
          tx_cnt_n   = 16'd0;
          txd_n      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = 16'd0;
          tx_bit_n   = 3'd0;
          txd_n      = tx_hold[0];
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = 16'd0;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n = tx_bit + 3'd1;
            txd_n    = tx_hold[tx_bit + 3'd1];
          end
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      TX_STOP: begin
        txd_n = 1'b1;
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = 16'd0;
        end else begin
          tx_cnt_n = tx_cnt + 16'd1;
        end
      end
      default: begin
        tx_state_n = TX_IDLE;
        tx_cnt_n   = 16'd0;
        txd_n      = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // RX engine
  // ---------------------------------------------------------------------
  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_s3 <= 1'b1;
    end else begin
      rxd_s1 <= uart_rxd;
      rxd_s2 <= rxd_s1;
      rxd_s3 <= rxd_s2;
    end
  end

  assign rx_fall = rxd_s3 && !rxd_s2;

  // RX state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= 16'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // RX next state: verify start at half bit, sample data and stop at centres
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_done    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_n = RX_START;
          rx_cnt_n   = 16'd0;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n = 16'd0;
          rx_bit_n = 3'd0;
          // A line that is high again at mid-start was only a glitch
          rx_state_n = rxd_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = 16'd0;
          rx_shift_n = {rxd_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else                rx_bit_n   = rx_bit + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = 16'd0;
          if (rxd_s2) begin
            rx_done    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            ferr_set   = 1'b1;
            rx_state_n = RX_WAIT;
          end
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_WAIT: begin
        if (rxd_s2) rx_state_n = RX_IDLE;
      end
      default: begin
        rx_state_n = RX_IDLE;
        rx_cnt_n   = 16'd0;
      end
    endcase
  end

  assign uart_txd       = txd_q;
  assign uart_interrupt = irq_q;
  assign uart_rack      = rack_q;
  assign uart_wack      = wack_q;
  assign uart_rdata     = rdata_q;

endmodule
